// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM word-bus controller: FSM states and phase-counter sizing.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    ACK
  } state_t;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MIN = 1;
  localparam int unsigned WAIT_MAX = 15;

endpackage

// File: rtl/sram_phase_timer.sv
// Phase counter for one SRAM half-access: counts 0..WAIT_CYCLES while run is high,
// flags the last cycle and whether the write strobe stays low in the following cycle.
module sram_phase_timer
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic last,
  output logic we_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] WE_END   = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || last) cnt <= '0;
    else                     cnt <= cnt + CNT_W'(1);
  end

  assign last = (cnt == CNT_LAST);
  // we_n is a registered output, so the window test looks one count ahead
  assign we_next = (cnt < WE_END);

endmodule

// File: rtl/sram_ctrl.sv
// Word-bus slave serving 32-bit accesses from a 16-bit async SRAM as two wait-stated halfword phases.
// Optional one-entry read buffer enabled by defining SRAM_RDBUF_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned SA_W        = 20,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stb,
  input  logic            we,
  input  logic [21:0]     addr,
  input  logic [31:0]     data_in,
  output logic [31:0]     data_out,
  output logic            ack,
  output logic [SA_W-1:0] sram_addr,
  input  logic [15:0]     sram_dq_i,
  output logic [15:0]     sram_dq_o,
  output logic            sram_dq_oe,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic            sram_ub_n,
  output logic            sram_lb_n
);

  localparam int unsigned WA_W = SA_W - 1;

  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_wait_range
    $error("sram_ctrl: WAIT_CYCLES must be within 1..15");
  end

  state_t          state;
  logic            req_we;
  logic [WA_W-1:0] req_word;
  logic [31:0]     req_data;
  logic            last;
  logic            we_next;
  logic            run;
  logic            lookup_hit;
  logic            unused_addr;

  assign unused_addr = ^addr[21:WA_W];

`ifdef SRAM_RDBUF_EN
  logic            buf_valid;
  logic [WA_W-1:0] buf_tag;
  logic [31:0]     buf_data;
  logic            hit_q;

  assign lookup_hit = !we && buf_valid && (buf_tag == addr[WA_W-1:0]);
  assign run        = ((state == LO) || (state == HI)) && !hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == HI && last) begin
      if (!req_we) begin
        buf_valid <= 1'b1;
        buf_tag   <= req_word;
        buf_data  <= {sram_dq_i, data_out[15:0]};
      end else if (buf_valid && buf_tag == req_word) begin
        buf_data  <= req_data;
      end
    end
  end
`else
  assign lookup_hit = 1'b0;
  assign run        = (state == LO) || (state == HI);
`endif

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .last   (last),
    .we_next(we_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ack        <= 1'b0;
      data_out   <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      req_we     <= 1'b0;
      req_word   <= '0;
      req_data   <= '0;
`ifdef SRAM_RDBUF_EN
      hit_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (stb) begin
            req_we   <= we;
            req_word <= addr[WA_W-1:0];
            req_data <= data_in;
            state    <= LO;
`ifdef SRAM_RDBUF_EN
            hit_q    <= lookup_hit;
`endif
            if (!lookup_hit) begin
              sram_addr <= {addr[WA_W-1:0], 1'b0};
              sram_ce_n <= 1'b0;
              sram_ub_n <= 1'b0;
              sram_lb_n <= 1'b0;
              if (we) begin
                sram_dq_oe <= 1'b1;
                sram_dq_o  <= data_in[15:0];
                sram_we_n  <= 1'b0;
              end else begin
                sram_oe_n  <= 1'b0;
              end
            end
          end
        end
        LO: begin
`ifdef SRAM_RDBUF_EN
          // A buffer hit spends one lookup cycle here with the SRAM left idle
          if (hit_q) begin
            hit_q    <= 1'b0;
            data_out <= buf_data;
            ack      <= 1'b1;
            state    <= ACK;
          end else
`endif
          if (last) begin
            if (!req_we) data_out[15:0] <= sram_dq_i;
            sram_addr <= {req_word, 1'b1};
            if (req_we) begin
              sram_dq_o <= req_data[31:16];
              sram_we_n <= 1'b0;
            end
            state <= HI;
          end else if (req_we) begin
            sram_we_n <= !we_next;
          end
        end
        HI: begin
          if (last) begin
            if (!req_we) data_out[31:16] <= sram_dq_i;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            ack        <= 1'b1;
            state      <= ACK;
          end else if (req_we) begin
            sram_we_n <= !we_next;
          end
        end
        ACK: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
